// File: rtl/gate_count_sequencer.sv
// Integration-window sequencer for the photon counter, driven by SPI command words.
// Define TRIG_SYNC_EN to pass trig_in through a SYNC_STAGES-flop synchronizer.
module gate_count_sequencer #(
    parameter int CNT_W        = 32,
    parameter int GATE_W       = 28,
    parameter int DEFAULT_GATE = 50000,
    parameter int LATCH_DELAY  = 2,
    parameter int SYNC_STAGES  = 2
) (
    input  logic             clk50Mhz,
    input  logic             rst,
    input  logic [31:0]      cmd_word,
    input  logic             cmd_valid,
    input  logic             trig_in,
    input  logic [CNT_W-1:0] cnt_in,
    output logic             cnt_clr,
    output logic             cnt_en,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    output logic [15:0]      frame_idx,
    output logic             busy,
    output logic             overrun
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_TRIG, S_CLEAR, S_GATE, S_LATCH
    } state_t;
    typedef enum logic [1:0] {M_SINGLE, M_TRIG, M_FREE} mode_t;

    state_t            r_state, w_next;
    mode_t             r_mode;
    logic [GATE_W-1:0] r_gate_len, r_down;
    logic [2:0]        r_lat_cnt;
    logic              r_stop_pend, r_trig_d;
    logic [CNT_W-1:0]  r_result;
    logic              r_result_valid, r_overrun;
    logic [15:0]       r_frame;

    logic [3:0]        w_op;
    logic [GATE_W-1:0] w_arg;
    logic w_set_gate, w_start_single, w_start_trig, w_free;
    logic w_stop, w_ack, w_clr_stat;
    logic w_trig_s, w_trig_edge, w_last_latch, w_capture, w_win_busy;

    assign w_op           = cmd_word[31:28];
    assign w_arg          = cmd_word[GATE_W-1:0];
    assign w_set_gate     = cmd_valid && (w_op == 4'h1);
    assign w_start_single = cmd_valid && (w_op == 4'h2);
    assign w_start_trig   = cmd_valid && (w_op == 4'h3);
    assign w_free         = cmd_valid && (w_op == 4'hF);
    assign w_stop         = cmd_valid && (w_op == 4'h0);
    assign w_ack          = cmd_valid && (w_op == 4'h5);
    assign w_clr_stat     = cmd_valid && (w_op == 4'h6);

`ifdef TRIG_SYNC_EN
    logic [SYNC_STAGES-1:0] r_sync;
    always_ff @(posedge clk50Mhz) begin
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], trig_in};
    end
    assign w_trig_s = r_sync[SYNC_STAGES-1];
`else
    assign w_trig_s = trig_in;
`endif

    assign w_trig_edge  = w_trig_s && !r_trig_d;
    assign w_last_latch = (r_lat_cnt == 3'(LATCH_DELAY - 1));
    assign w_capture    = (r_state == S_LATCH) && w_last_latch;
    assign w_win_busy   = (r_state == S_CLEAR) || (r_state == S_GATE) ||
                          (r_state == S_LATCH);

    always_ff @(posedge clk50Mhz) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start_single || w_free) w_next = S_CLEAR;
                else if (w_start_trig)        w_next = S_WAIT_TRIG;
            end
            S_WAIT_TRIG: begin
                if (w_stop)           w_next = S_IDLE;
                else if (w_trig_edge) w_next = S_CLEAR;
            end
            S_CLEAR: w_next = S_GATE;
            S_GATE: begin
                if (w_stop || r_stop_pend ||
                    (r_mode != M_FREE && r_down == '0))
                    w_next = S_LATCH;
            end
            S_LATCH: begin
                if (w_last_latch)
                    w_next = (r_mode == M_TRIG && !r_stop_pend && !w_stop)
                             ? S_WAIT_TRIG : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk50Mhz) begin
        if (rst) begin
            r_mode         <= M_SINGLE;
            r_gate_len     <= GATE_W'(DEFAULT_GATE);
            r_down         <= '0;
            r_lat_cnt      <= '0;
            r_stop_pend    <= 1'b0;
            r_trig_d       <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_frame        <= '0;
            r_overrun      <= 1'b0;
        end else begin
            r_trig_d <= w_trig_s;
            if (w_set_gate)
                r_gate_len <= (w_arg == '0) ? GATE_W'(1) : w_arg;
            if (r_state == S_IDLE) begin
                if (w_start_single)    r_mode <= M_SINGLE;
                else if (w_start_trig) r_mode <= M_TRIG;
                else if (w_free)       r_mode <= M_FREE;
                if (w_clr_stat) begin
                    r_frame   <= '0;
                    r_overrun <= 1'b0;
                end
            end
            // Down-counter snapshots gate_len so SET_GATE never disturbs a live window
            if (r_state == S_CLEAR)
                r_down <= r_gate_len - GATE_W'(1);
            else if (r_state == S_GATE && r_down != '0)
                r_down <= r_down - GATE_W'(1);
            r_lat_cnt <= (r_state == S_LATCH) ? r_lat_cnt + 3'd1 : 3'd0;
            if (!w_win_busy)
                r_stop_pend <= 1'b0;
            else if (w_stop)
                r_stop_pend <= 1'b1;
            if (w_capture) begin
                r_result       <= cnt_in;
                r_result_valid <= 1'b1;
                r_frame        <= r_frame + 16'd1;
                if (r_result_valid && !w_ack) r_overrun <= 1'b1;
            end else if (w_ack) begin
                r_result_valid <= 1'b0;
            end
            if (w_trig_edge && r_mode == M_TRIG && w_win_busy)
                r_overrun <= 1'b1;
        end
    end

    assign cnt_clr      = (r_state == S_CLEAR);
    assign cnt_en       = (r_state == S_GATE);
    assign busy         = (r_state != S_IDLE);
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign frame_idx    = r_frame;
    assign overrun      = r_overrun;
endmodule
